mm_lsu: RTL and testbench

//  Multi-cycle load/store unit for the MEM stage. Accepts one access from EX, runs a req/ack handshake to the memory bus,
//  and stalls the pipeline until done. Sub-word stores are a single byte-enabled write or a read-modify-write (RMW).

---
 rtl/mm_lsu_pkg.sv | 47 ++++
 rtl/mm_lsu_align.sv | 81 ++++++++
 rtl/mm_lsu.sv | 212 +++++++++++++++++++++
 tb/tb_mm_lsu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access encodings,
// FSM state encodings, the latched-operand payload and the alignment check.
package mm_lsu_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned ST_W   = 3;

  // Memory access type (EX -> MEM)
  localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_NONE = 2'd0;
  localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_M2R  = 2'd1;
  localparam logic [TYPE_W-1:0] MEM_ACCESS_TYPE_R2M  = 2'd2;

  // Memory access length
  localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_BYTE       = 3'd0;
  localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_HALF       = 3'd1;
  localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_WORD       = 3'd2;
  localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_LEFT_WORD  = 3'd3;
  localparam logic [SIZE_W-1:0] MEM_ACCESS_LENGTH_RIGHT_WORD = 3'd4;

  // LSU FSM states
  localparam logic [ST_W-1:0] MM_ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] MM_ST_RD     = 3'd1;
  localparam logic [ST_W-1:0] MM_ST_WR     = 3'd2;
  localparam logic [ST_W-1:0] MM_ST_RMW_RD = 3'd3;
  localparam logic [ST_W-1:0] MM_ST_RMW_WR = 3'd4;
  localparam logic [ST_W-1:0] MM_ST_DONE   = 3'd5;

  // Operands held from accept until the FSM returns to IDLE
  typedef struct packed {
    logic [SIZE_W-1:0] size;
    logic              sgn;
    logic [1:0]        a;
    logic [DATA_W-1:0] data;
  } lsu_op_t;

  // HALF must be half-aligned, WORD word-aligned; LWL/LWR/byte never fault
  function automatic logic misaligned(input logic [SIZE_W-1:0] size, input logic [1:0] a);
    return ((size == MEM_ACCESS_LENGTH_HALF) && a[0]) ||
           ((size == MEM_ACCESS_LENGTH_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mm_lsu_align.sv
// Combinational lane logic for the LSU.
//  a_i         byte offset within the word
//  size_i      access length, sgn_i sign-extend for BYTE/HALF loads
//  data_i      store data, or old rt value for LWL/LWR
//  rdata_i     word read from the bus
//  be_o        store byte enables, wdata_o lane-replicated/shifted store data
//  rmw_wdata_o read word merged with wdata_o under be_o
//  load_data_o extracted/extended/merged load result
module mm_lsu_align
  import mm_lsu_pkg::*;
(
  input  logic [1:0]        a_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              sgn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [BE_W-1:0]   be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rmw_wdata_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [4:0]  sh_r;   // a*8
  logic [4:0]  sh_l;   // (3-a)*8
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store lane generation
  always_comb begin
    sh_r    = {a_i, 3'b000};
    sh_l    = {2'd3 - a_i, 3'b000};
    be_o    = 4'hf;
    wdata_o = data_i;
    case (size_i)
      MEM_ACCESS_LENGTH_BYTE: begin
        be_o    = 4'b0001 << a_i;
        wdata_o = {4{data_i[7:0]}};
      end
      MEM_ACCESS_LENGTH_HALF: begin
        be_o    = a_i[1] ? 4'hc : 4'h3;
        wdata_o = {2{data_i[15:0]}};
      end
      MEM_ACCESS_LENGTH_LEFT_WORD: begin
        be_o    = 4'hf >> (2'd3 - a_i);
        wdata_o = data_i >> sh_l;
      end
      MEM_ACCESS_LENGTH_RIGHT_WORD: begin
        be_o    = 4'hf << a_i;
        wdata_o = data_i << sh_r;
      end
      default: ;
    endcase
  end

  // RMW merge: enabled lanes from store data, the rest from the read word
  always_comb begin
    rmw_wdata_o = rdata_i;
    for (int n = 0; n < 4; n++) begin
      if (be_o[n]) rmw_wdata_o[8*n +: 8] = wdata_o[8*n +: 8];
    end
  end

  // Load extraction and LWL/LWR merge
  always_comb begin
    byte_v      = 8'(rdata_i >> sh_r);
    half_v      = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o = rdata_i;
    case (size_i)
      MEM_ACCESS_LENGTH_BYTE:
        load_data_o = sgn_i ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
      MEM_ACCESS_LENGTH_HALF:
        load_data_o = sgn_i ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
      MEM_ACCESS_LENGTH_LEFT_WORD:
        load_data_o = (rdata_i << sh_l) | (data_i & ~(32'hffff_ffff << sh_l));
      MEM_ACCESS_LENGTH_RIGHT_WORD:
        load_data_o = (rdata_i >> sh_r) | (data_i & ~(32'hffff_ffff >> sh_r));
      default: ;
    endcase
  end

endmodule

// File: rtl/mm_lsu.sv
// Multi-cycle MEM-stage load/store unit with req/ack bus handshake.
//  EX side : req_valid, mem_type, mem_size, mem_signed, addr_i, data_i, reg_addr_i
//  Pipeline: stall_o (combinational), done_valid, data_o, reg_addr_o,
//            alignment_err, bus_err
//  Bus     : bus_req, bus_we, bus_addr, bus_be, bus_wdata, bus_rdata, bus_ack
// All outputs except stall_o are registered.
module mm_lsu
  import mm_lsu_pkg::*;
#(
  parameter bit          USE_BYTE_EN = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [TYPE_W-1:0] mem_type,
  input  logic [SIZE_W-1:0] mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [REG_W-1:0]  reg_addr_i,
  output logic              stall_o,
  output logic              done_valid,
  output logic [DATA_W-1:0] data_o,
  output logic [REG_W-1:0]  reg_addr_o,
  output logic              alignment_err,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BE_W-1:0]   bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  lsu_op_t           op_q, op_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [REG_W-1:0]  reg_q, reg_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              idle_c, is_load_c, is_store_c, bad_c, busy_c;
  logic              ack_c, expire_c;
  lsu_op_t           al_op_c;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata, al_rmw, al_load;

  // In IDLE the lanes are computed from live inputs so accept can register them
  assign idle_c     = (state_q == MM_ST_IDLE);
  assign is_load_c  = (mem_type == MEM_ACCESS_TYPE_M2R);
  assign is_store_c = (mem_type == MEM_ACCESS_TYPE_R2M);
  assign bad_c      = misaligned(mem_size, addr_i[1:0]);
  assign al_op_c    = idle_c ? '{size: mem_size, sgn: mem_signed, a: addr_i[1:0], data: data_i}
                             : op_q;

  mm_lsu_align u_align (
    .a_i         (al_op_c.a),
    .size_i      (al_op_c.size),
    .sgn_i       (al_op_c.sgn),
    .data_i      (al_op_c.data),
    .rdata_i     (bus_rdata),
    .be_o        (al_be),
    .wdata_o     (al_wdata),
    .rmw_wdata_o (al_rmw),
    .load_data_o (al_load)
  );

  assign busy_c   = (state_q == MM_ST_RD) || (state_q == MM_ST_WR) ||
                    (state_q == MM_ST_RMW_RD) || (state_q == MM_ST_RMW_WR);
  // An ack with no outstanding request is ignored
  assign ack_c    = bus_ack & req_q;
  // Fires on the TIMEOUT-th consecutive cycle without ack
  assign expire_c = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

  assign stall_o  = busy_c ||
                    (idle_c && req_valid && (is_load_c || is_store_c) && !bad_c);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MM_ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      reg_q       <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      done_q      <= done_d;
      data_q      <= data_d;
      reg_q       <= reg_d;
      align_err_q <= align_err_d;
      bus_err_q   <= bus_err_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    done_d      = 1'b0;
    data_d      = data_q;
    reg_d       = reg_q;
    align_err_d = 1'b0;
    bus_err_d   = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;

    case (state_q)
      MM_ST_IDLE: begin
        if (req_valid) begin
          if ((is_load_c || is_store_c) && bad_c) begin
            align_err_d = 1'b1;
          end else if (!is_load_c && !is_store_c) begin
            data_d  = data_i;
            reg_d   = reg_addr_i;
            done_d  = 1'b1;
            state_d = MM_ST_DONE;
          end else begin
            op_d   = al_op_c;
            reg_d  = reg_addr_i;
            addr_d = {addr_i[ADDR_W-1:2], 2'b00};
            cnt_d  = '0;
            req_d  = 1'b1;
            if (is_load_c) begin
              we_d    = 1'b0;
              state_d = MM_ST_RD;
            end else if (USE_BYTE_EN || (mem_size == MEM_ACCESS_LENGTH_WORD)) begin
              we_d    = 1'b1;
              be_d    = al_be;
              wdata_d = al_wdata;
              state_d = MM_ST_WR;
            end else begin
              we_d    = 1'b0;
              state_d = MM_ST_RMW_RD;
            end
          end
        end
      end

      MM_ST_RD, MM_ST_RMW_RD, MM_ST_WR, MM_ST_RMW_WR: begin
        if (ack_c) begin
          if (state_q == MM_ST_RMW_RD) begin
            // Read phase done; request stays up for the merged full-word write
            we_d    = 1'b1;
            be_d    = 4'hf;
            wdata_d = al_rmw;
            cnt_d   = '0;
            state_d = MM_ST_RMW_WR;
          end else begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            data_d  = (state_q == MM_ST_RD) ? al_load : op_q.data;
            done_d  = 1'b1;
            state_d = MM_ST_DONE;
          end
        end else if (expire_c) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          bus_err_d = 1'b1;
          state_d   = MM_ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      MM_ST_DONE: state_d = MM_ST_IDLE;

      default: state_d = MM_ST_IDLE;
    endcase
  end

  assign done_valid    = done_q;
  assign data_o        = data_q;
  assign reg_addr_o    = reg_q;
  assign alignment_err = align_err_q;
  assign bus_err       = bus_err_q;
  assign bus_req       = req_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_be        = be_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mm_lsu.sv
// Directed bench for mm_lsu. Instance A uses byte-enabled stores, instance B
// uses read-modify-write; both time out after 4 unacknowledged cycles.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mm_lsu;
  import mm_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic [1:0]  mem_type;
  logic [2:0]  mem_size;
  logic        mem_signed;
  logic [31:0] addr, data;
  logic [4:0]  reg_addr;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  logic        a_stall, a_done, a_aerr, a_berr, a_req, a_we;
  logic [31:0] a_data, a_baddr, a_wdata;
  logic [4:0]  a_reg;
  logic [3:0]  a_be;
  logic        b_stall, b_done, b_aerr, b_berr, b_req, b_we;
  logic [31:0] b_data, b_baddr, b_wdata;
  logic [4:0]  b_reg;
  logic [3:0]  b_be;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mm_lsu #(.USE_BYTE_EN(1'b1), .TIMEOUT(4), .TO_W(8)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .mem_type(mem_type),
    .mem_size(mem_size), .mem_signed(mem_signed), .addr_i(addr), .data_i(data),
    .reg_addr_i(reg_addr), .stall_o(a_stall), .done_valid(a_done), .data_o(a_data),
    .reg_addr_o(a_reg), .alignment_err(a_aerr), .bus_err(a_berr), .bus_req(a_req),
    .bus_we(a_we), .bus_addr(a_baddr), .bus_be(a_be), .bus_wdata(a_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  mm_lsu #(.USE_BYTE_EN(1'b0), .TIMEOUT(4), .TO_W(8)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .mem_type(mem_type),
    .mem_size(mem_size), .mem_signed(mem_signed), .addr_i(addr), .data_i(data),
    .reg_addr_i(reg_addr), .stall_o(b_stall), .done_valid(b_done), .data_o(b_data),
    .reg_addr_o(b_reg), .alignment_err(b_aerr), .bus_err(b_berr), .bus_req(b_req),
    .bus_we(b_we), .bus_addr(b_baddr), .bus_be(b_be), .bus_wdata(b_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [2:0] s, input logic sg,
                       input logic [31:0] ad, input logic [31:0] d, input logic [4:0] r);
    mem_type = t; mem_size = s; mem_signed = sg; addr = ad; data = d; reg_addr = r;
  endtask

  initial begin
    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0;
    drive(MEM_ACCESS_TYPE_NONE, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h0, 32'h0, 5'd0);
    bus_rdata = 32'h0; bus_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_data",  a_data,       32'd0);
    chk("rst_req",   32'(a_req),   32'd0);
    chk("rst_errs",  32'({a_aerr, a_berr, b_aerr, b_berr}), 32'd0);

    // LB signed @0x103 -> 0xffffff80; done in 3rd cycle counting the accept cycle
    drive(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_BYTE, 1'b1, 32'h103, 32'h0, 5'd7);
    req_valid_a = 1'b1;
    #1 chk("lb_stall_accept", 32'(a_stall), 32'd1);
    tick(); req_valid_a = 1'b0;
    chk("lb_req",   32'(a_req),  32'd1);
    chk("lb_we",    32'(a_we),   32'd0);
    chk("lb_addr",  a_baddr,     32'h100);
    chk("lb_done0", 32'(a_done), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h80aabbcc;
    tick(); bus_ack = 1'b0;
    chk("lb_done",  32'(a_done),  32'd1);
    chk("lb_data",  a_data,       32'hffffff80);
    chk("lb_reg",   32'(a_reg),   32'd7);
    chk("lb_req_dropped", 32'(a_req), 32'd0);
    chk("lb_stall_done", 32'(a_stall), 32'd0);
    tick();
    chk("lb_done_pulse", 32'(a_done), 32'd0);

    // SH @0x202, byte enables
    drive(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_HALF, 1'b0, 32'h202, 32'h1234, 5'd3);
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    chk("sh_we",    32'(a_we), 32'd1);
    chk("sh_be",    32'(a_be), 32'hc);
    chk("sh_wdata", a_wdata,   32'h12341234);
    chk("sh_addr",  a_baddr,   32'h200);
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    chk("sh_done",  32'(a_done), 32'd1);
    chk("sh_data",  a_data,      32'h1234);
    chk("sh_req",   32'(a_req),  32'd0);
    tick();

    // SB via RMW on instance B: read, then merged full-word write, done in 4th cycle
    drive(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_BYTE, 1'b0, 32'h1, 32'h5a, 5'd0);
    req_valid_b = 1'b1;
    tick(); req_valid_b = 1'b0;
    chk("rmw_rd_req", 32'({b_req, b_we}), 32'h2);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    tick();
    chk("rmw_wr_req",  32'({b_req, b_we}), 32'h3);
    chk("rmw_be",      32'(b_be),   32'hf);
    chk("rmw_wdata",   b_wdata,     32'h11225a44);
    chk("rmw_done0",   32'(b_done), 32'd0);
    tick(); bus_ack = 1'b0;
    chk("rmw_done",    32'(b_done), 32'd1);
    chk("rmw_req_off", 32'(b_req),  32'd0);
    tick();

    // LW @0x6 misaligned: error pulse only
    drive(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h6, 32'h0, 5'd1);
    req_valid_a = 1'b1;
    #1 chk("mis_stall", 32'(a_stall), 32'd0);
    tick(); req_valid_a = 1'b0;
    chk("mis_aerr", 32'(a_aerr), 32'd1);
    chk("mis_req",  32'(a_req),  32'd0);
    tick();
    chk("mis_aerr_pulse", 32'(a_aerr), 32'd0);
    chk("mis_no_done", 32'({a_done, a_req}), 32'd0);

    // LWL @0x1
    drive(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_LEFT_WORD, 1'b0, 32'h1, 32'h11223344, 5'd2);
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'haabbccdd;
    tick(); bus_ack = 1'b0;
    chk("lwl_data", a_data, 32'hccdd3344);
    tick();

    // LWR @0x2
    drive(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h2, 32'h11223344, 5'd2);
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'haabbccdd;
    tick(); bus_ack = 1'b0;
    chk("lwr_data", a_data, 32'h1122aabb);
    tick();

    // SWR @0x2
    drive(MEM_ACCESS_TYPE_R2M, MEM_ACCESS_LENGTH_RIGHT_WORD, 1'b0, 32'h2, 32'h11223344, 5'd0);
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    chk("swr_be",    32'(a_be), 32'hc);
    chk("swr_wdata", a_wdata,   32'h33440000);
    bus_ack = 1'b1;
    tick(); bus_ack = 1'b0;
    tick();

    // Non-memory pass-through, no stall
    drive(MEM_ACCESS_TYPE_NONE, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h0, 32'hcafef00d, 5'd9);
    req_valid_a = 1'b1;
    #1 chk("none_stall", 32'(a_stall), 32'd0);
    tick(); req_valid_a = 1'b0;
    chk("none_done", 32'(a_done), 32'd1);
    chk("none_data", a_data,      32'hcafef00d);
    chk("none_reg",  32'(a_reg),  32'd9);
    tick();

    // Timeout: bus_err after the 4th unacknowledged RD cycle
    drive(MEM_ACCESS_TYPE_M2R, MEM_ACCESS_LENGTH_WORD, 1'b0, 32'h40, 32'h0, 5'd4);
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_req", 32'({a_req, a_berr}), 32'h2);
    end
    tick();
    chk("to_berr",  32'(a_berr), 32'd1);
    chk("to_req",   32'(a_req),  32'd0);
    chk("to_done",  32'(a_done), 32'd0);
    tick();
    chk("to_berr_pulse", 32'(a_berr), 32'd0);

    // Ack in the same cycle as expiry completes the access
    req_valid_a = 1'b1;
    #1 chk("race_idle_stall", 32'(a_stall), 32'd1);
    tick(); req_valid_a = 1'b0;
    tick(); tick(); tick();
    bus_ack = 1'b1; bus_rdata = 32'hdeadbeef;
    tick(); bus_ack = 1'b0;
    chk("race_done", 32'(a_done), 32'd1);
    chk("race_berr", 32'(a_berr), 32'd0);
    chk("race_data", a_data,      32'hdeadbeef);
    tick();

    // Reset mid-RD aborts with all outputs cleared
    req_valid_a = 1'b1;
    tick(); req_valid_a = 1'b0;
    tick();
    chk("pre_rst_req", 32'(a_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req",   32'({a_req, a_we, a_done, a_berr, a_aerr, a_stall}), 32'd0);
    chk("mid_rst_addr",  a_baddr, 32'd0);
    chk("mid_rst_data",  a_data,  32'd0);
    tick();
    chk("post_rst_done", 32'({a_done, a_req}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
